// File: rtl/lsu_pkg.sv
// Shared types and constants for the APB load/store unit.
//   lsu_state_t : control FSM states
//   lsu_size_t  : access size encoding carried on req_size
//   ERR_*       : response error codes driven on rsp_err
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_t;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_BUS     = 2'd1;
   localparam logic [1:0] ERR_ALIGN   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
//   i_size      : access size (lsu_size_t encoding)
//   i_off       : byte offset of the access within the bus word
//   i_signed    : sign-extend load data when 1
//   i_wdata     : right-justified store data
//   i_prdata    : raw APB read data
//   o_pdata     : store data replicated across every lane of its size
//   o_pstb      : write strobes for the addressed lanes
//   o_rdata_ext : load data shifted down to bit 0, masked to size and extended
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned STRB_W = DATA_WIDTH / 8,
   localparam int unsigned OFF_W  = $clog2(STRB_W)
) (
   input  logic [1:0]            i_size,
   input  logic [OFF_W-1:0]      i_off,
   input  logic                  i_signed,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_prdata,
   output logic [DATA_WIDTH-1:0] o_pdata,
   output logic [STRB_W-1:0]     o_pstb,
   output logic [DATA_WIDTH-1:0] o_rdata_ext
);

   logic [DATA_WIDTH-1:0] w_shift;
   logic [DATA_WIDTH-1:0] w_keep;
   logic [STRB_W-1:0]     w_base_stb;
   logic                  w_sign;

   assign w_shift = i_prdata >> {i_off, 3'b000};

   always_comb begin
      o_pdata    = '0;
      w_base_stb = '0;
      w_keep     = '0;
      w_sign     = 1'b0;
      unique case (lsu_size_t'(i_size))
         SZ_B: begin
            o_pdata    = {STRB_W{i_wdata[7:0]}};
            w_base_stb = STRB_W'(1);
            w_keep     = DATA_WIDTH'(8'hFF);
            w_sign     = w_shift[7];
         end
         SZ_H: begin
            o_pdata    = {(STRB_W / 2){i_wdata[15:0]}};
            w_base_stb = STRB_W'(2'b11);
            w_keep     = DATA_WIDTH'(16'hFFFF);
            w_sign     = w_shift[15];
         end
         SZ_W: begin
            o_pdata    = {(STRB_W / 4){i_wdata[31:0]}};
            w_base_stb = STRB_W'(4'hF);
            w_keep     = DATA_WIDTH'(32'hFFFF_FFFF);
            w_sign     = w_shift[31];
         end
         SZ_D: begin
            // Only reachable on a 64-bit bus; fills the whole word, nothing to extend.
            o_pdata    = i_wdata;
            w_base_stb = '1;
            w_keep     = '1;
            w_sign     = 1'b0;
         end
      endcase
   end

   assign o_pstb      = w_base_stb << i_off;
   assign o_rdata_ext = (w_shift & w_keep) | ((i_signed && w_sign) ? ~w_keep : '0);

endmodule

// File: rtl/apb_lsu.sv
// Load/store unit: runs one core memory request as a single APB master access.
//   i_clk / i_rst_n          : clock, asynchronous active-low reset
//   i_req_* / o_req_ready    : request handshake (write, size, signed, addr, wdata)
//   o_rsp_valid/rdata/err    : one-cycle response pulse with extended load data and error code
//   o_apb_* / i_apb_*        : APB master interface (psel, penable, pwrite, paddr, pdata,
//                              pstb, prdata, pready, perr)
// All outputs are registered except o_req_ready, which decodes the IDLE state.
module apb_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned STRB_W = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_signed,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [1:0]            o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_apb_paddr,
   output logic [DATA_WIDTH-1:0] o_apb_pdata,
   input  logic [DATA_WIDTH-1:0] i_apb_prdata,
   output logic                  o_apb_psel,
   output logic                  o_apb_penable,
   output logic                  o_apb_pwrite,
   output logic [STRB_W-1:0]     o_apb_pstb,
   input  logic                  i_apb_pready,
   input  logic                  i_apb_perr
);

   localparam int unsigned OFF_W = $clog2(STRB_W);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t r_state, w_state_nxt;

   // Request fields latched at acceptance
   logic             r_write;
   logic             r_signed;
   logic [1:0]       r_size;
   logic [OFF_W-1:0] r_off;
   logic [CNT_W-1:0] r_cnt;

   // Registered outputs and their next values
   logic                  r_psel, w_psel;
   logic                  r_penable, w_penable;
   logic                  r_pwrite, w_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
   logic [DATA_WIDTH-1:0] r_pdata, w_pdata;
   logic [STRB_W-1:0]     r_pstb, w_pstb;
   logic                  r_rsp_valid, w_rsp_valid;
   logic [1:0]            r_rsp_err, w_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;

   logic                  w_idle;
   logic                  w_accept;
   logic                  w_misaligned;
   logic                  w_timeout;
   logic [OFF_W-1:0]      w_req_off;
   logic [1:0]            w_ln_size;
   logic [OFF_W-1:0]      w_ln_off;
   logic [DATA_WIDTH-1:0] w_ln_pdata;
   logic [STRB_W-1:0]     w_ln_pstb;
   logic [DATA_WIDTH-1:0] w_ln_rdata;

   assign w_idle      = (r_state == IDLE);
   assign o_req_ready = w_idle;
   assign w_accept    = w_idle && i_req_valid;
   assign w_req_off   = i_req_addr[OFF_W-1:0];

   always_comb begin
      w_misaligned = 1'b0;
      unique case (lsu_size_t'(i_req_size))
         SZ_B: w_misaligned = 1'b0;
         SZ_H: w_misaligned = i_req_addr[0];
         SZ_W: w_misaligned = |i_req_addr[1:0];
         SZ_D: w_misaligned = (DATA_WIDTH == 32) || (|i_req_addr[2:0]);
      endcase
   end

   // pready has priority: timeout only fires on a cycle where pready is low
   assign w_timeout = (r_state == ACCESS) && !i_apb_pready && (TIMEOUT_CYCLES != 0) &&
                      (r_cnt == CNT_LAST);

   // One aligner serves both directions: request fields while idle, latched ones afterwards
   assign w_ln_size = w_idle ? i_req_size : r_size;
   assign w_ln_off  = w_idle ? w_req_off  : r_off;

   lsu_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .i_size      (w_ln_size),
      .i_off       (w_ln_off),
      .i_signed    (r_signed),
      .i_wdata     (i_req_wdata),
      .i_prdata    (i_apb_prdata),
      .o_pdata     (w_ln_pdata),
      .o_pstb      (w_ln_pstb),
      .o_rdata_ext (w_ln_rdata)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_misaligned ? RESP : SETUP;
            end
         end
         SETUP:  w_state_nxt = ACCESS;
         ACCESS: begin
            if (i_apb_pready || w_timeout) begin
               w_state_nxt = RESP;
            end
         end
         RESP:   w_state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      w_psel      = r_psel;
      w_penable   = r_penable;
      w_pwrite    = r_pwrite;
      w_paddr     = r_paddr;
      w_pdata     = r_pdata;
      w_pstb      = r_pstb;
      w_rsp_valid = 1'b0;
      w_rsp_err   = r_rsp_err;
      w_rsp_rdata = r_rsp_rdata;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_misaligned) begin
                  w_rsp_valid = 1'b1;
                  w_rsp_err   = ERR_ALIGN;
                  w_rsp_rdata = '0;
               end else begin
                  w_psel    = 1'b1;
                  w_penable = 1'b0;
                  w_pwrite  = i_req_write;
                  w_paddr   = i_req_addr;
                  w_pdata   = w_ln_pdata;
                  // APB has no read mask, so reads always enable every lane
                  w_pstb    = i_req_write ? w_ln_pstb : '1;
               end
            end
         end
         SETUP: begin
            w_penable = 1'b1;
         end
         ACCESS: begin
            if (i_apb_pready) begin
               w_psel      = 1'b0;
               w_penable   = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_err   = i_apb_perr ? ERR_BUS : ERR_OK;
               w_rsp_rdata = (!r_write && !i_apb_perr) ? w_ln_rdata : '0;
            end else if (w_timeout) begin
               w_psel      = 1'b0;
               w_penable   = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_err   = ERR_TIMEOUT;
               w_rsp_rdata = '0;
            end
         end
         RESP: begin
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pdata     <= '0;
         r_pstb      <= '1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= ERR_OK;
         r_rsp_rdata <= '0;
      end else begin
         r_psel      <= w_psel;
         r_penable   <= w_penable;
         r_pwrite    <= w_pwrite;
         r_paddr     <= w_paddr;
         r_pdata     <= w_pdata;
         r_pstb      <= w_pstb;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_err   <= w_rsp_err;
         r_rsp_rdata <= w_rsp_rdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_size   <= SZ_B;
         r_off    <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_write  <= i_req_write;
            r_signed <= i_req_signed;
            r_size   <= i_req_size;
            r_off    <= w_req_off;
         end
         // Counts ACCESS cycles; starts from 0 on every ACCESS entry
         r_cnt <= (r_state == ACCESS) ? r_cnt + CNT_W'(1) : '0;
      end
   end

   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_err     = r_rsp_err;
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_apb_psel    = r_psel;
   assign o_apb_penable = r_penable;
   assign o_apb_pwrite  = r_pwrite;
   assign o_apb_paddr   = r_paddr;
   assign o_apb_pdata   = r_pdata;
   assign o_apb_pstb    = r_pstb;

endmodule

// File: tb/tb_apb_lsu.sv
// Bench for apb_lsu: a 32-bit instance (timeout 8) with a scripted APB slave, and a 64-bit
// instance (timeout disabled, zero wait states). Expected responses are queued at issue time
// and popped by monitors whenever rsp_valid is seen.
module tb_apb_lsu;
   import lsu_pkg::*;

   localparam int unsigned TMO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // 32-bit DUT signals
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata, paddr, pdata, prdata;
   logic        rsp_valid, psel, penable, pwrite, pready, perr;
   logic [3:0]  pstb;

   // 64-bit DUT signals
   logic        q_req_valid, q_req_ready, q_req_write, q_req_signed;
   logic [1:0]  q_req_size, q_rsp_err;
   logic [31:0] q_req_addr, q_paddr;
   logic [63:0] q_req_wdata, q_rsp_rdata, q_pdata, q_prdata;
   logic        q_rsp_valid, q_psel, q_penable, q_pwrite;
   logic        q_pready = 1'b1;
   logic        q_perr = 1'b0;
   logic [7:0]  q_pstb;

   apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_apb_paddr(paddr), .o_apb_pdata(pdata), .i_apb_prdata(prdata),
      .o_apb_psel(psel), .o_apb_penable(penable), .o_apb_pwrite(pwrite), .o_apb_pstb(pstb),
      .i_apb_pready(pready), .i_apb_perr(perr)
   );

   apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0)) dut64 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(q_req_valid), .o_req_ready(q_req_ready), .i_req_write(q_req_write),
      .i_req_size(q_req_size), .i_req_signed(q_req_signed), .i_req_addr(q_req_addr),
      .i_req_wdata(q_req_wdata), .o_rsp_valid(q_rsp_valid), .o_rsp_rdata(q_rsp_rdata),
      .o_rsp_err(q_rsp_err), .o_apb_paddr(q_paddr), .o_apb_pdata(q_pdata),
      .i_apb_prdata(q_prdata), .o_apb_psel(q_psel), .o_apb_penable(q_penable),
      .o_apb_pwrite(q_pwrite), .o_apb_pstb(q_pstb), .i_apb_pready(q_pready),
      .i_apb_perr(q_perr)
   );

   typedef struct {
      logic [1:0]  err;
      logic [63:0] rdata;
      int unsigned cyc;
   } rsp_t;

   typedef struct {
      int          waits;
      bit          perr;
      bit          tmo;
      bit          abort;
      logic [31:0] prdata;
      logic [31:0] addr;
      bit          write;
      logic [7:0]  pstb;
      logic [63:0] pdata;
   } slv_t;

   rsp_t exp_q[$];
   rsp_t exp64_q[$];
   slv_t slv_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference model: byte-by-byte view of the access
   function automatic bit m_misaligned(int dbytes, logic [31:0] addr, int sz);
      int nb;
      nb = 1 << sz;
      return (sz == 3 && dbytes == 4) || ((int'(addr[2:0]) % nb) != 0);
   endfunction

   function automatic logic [63:0] m_load(logic [63:0] prd, int off, int sz, bit sgn);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = prd[8*(off+i) +: 8];
      if (sgn && v[8*nb-1]) for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [63:0] m_pdata(int dbytes, logic [63:0] wd, int sz);
      int nb;
      logic [63:0] p;
      nb = 1 << sz;
      p = '0;
      for (int i = 0; i < dbytes; i++) p[8*i +: 8] = wd[8*(i % nb) +: 8];
      return p;
   endfunction

   function automatic logic [7:0] m_pstb(int off, int sz);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < (1 << sz); i++) s[off+i] = 1'b1;
      return s;
   endfunction

   task automatic issue(input bit wr, input int sz, input bit sgn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] prd, input int waits,
                        input bit be, input bit tmo, input bit abort);
      rsp_t r;
      slv_t s;
      int b, off;
      logic [63:0] ld;
      b = 0;
      @(negedge clk);
      while (!req_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      off = int'(addr[1:0]);
      req_valid = 1'b1; req_write = wr; req_size = 2'(sz); req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      r.cyc = cyc + 1;
      r.rdata = '0;
      if (m_misaligned(4, addr, sz)) begin
         r.err = ERR_ALIGN;
      end else begin
         s.waits = waits; s.perr = be; s.tmo = tmo; s.abort = abort; s.prdata = prd;
         s.addr = addr; s.write = wr;
         s.pstb = wr ? m_pstb(off, sz) : 8'h0F;
         s.pdata = m_pdata(4, {32'h0, wd}, sz);
         slv_q.push_back(s);
         if (tmo) begin
            r.err = ERR_TIMEOUT;
            r.cyc = r.cyc + 1 + TMO;
         end else begin
            r.err = be ? ERR_BUS : ERR_OK;
            r.cyc = r.cyc + 2 + waits;
            if (!wr && !be) begin
               ld = m_load({32'h0, prd}, off, sz, sgn);
               r.rdata = {32'h0, ld[31:0]};
            end
         end
      end
      if (!abort) exp_q.push_back(r);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic issue64(input bit wr, input int sz, input bit sgn, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [63:0] prd);
      rsp_t r;
      int b, off;
      bit mis;
      b = 0;
      @(negedge clk);
      while (!q_req_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("q_req_ready_wait", 64'(q_req_ready), 64'd1);
      off = int'(addr[2:0]);
      mis = m_misaligned(8, addr, sz);
      q_req_valid = 1'b1; q_req_write = wr; q_req_size = 2'(sz); q_req_signed = sgn;
      q_req_addr = addr; q_req_wdata = wd; q_prdata = prd;
      r.cyc = cyc + 1;
      r.rdata = '0;
      if (mis) begin
         r.err = ERR_ALIGN;
      end else begin
         r.err = ERR_OK;
         r.cyc = r.cyc + 2;
         if (!wr) r.rdata = m_load(prd, off, sz, sgn);
      end
      exp64_q.push_back(r);
      @(negedge clk);
      q_req_valid = 1'b0;
      if (mis) begin
         chk("q_psel_mis", 64'(q_psel), 64'd0);
      end else begin
         chk("q_setup_psel", {62'd0, q_psel, q_penable}, 64'd2);
         chk("q_paddr", 64'(q_paddr), 64'(addr));
         chk("q_pstb", 64'(q_pstb), wr ? 64'(m_pstb(off, sz)) : 64'hFF);
         if (wr) chk("q_pdata", q_pdata, m_pdata(8, wd, sz));
      end
   endtask

   // APB slave for the 32-bit instance, scripted by slv_q
   initial begin : slave32
      slv_t s;
      int n;
      pready = 1'b0; perr = 1'b0; prdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && psel && !penable) begin
            if (slv_q.size() == 0) begin
               chk("apb_unexpected_psel", 64'(psel), 64'd0);
            end else begin
               s = slv_q.pop_front();
               chk("apb_paddr", 64'(paddr), 64'(s.addr));
               chk("apb_pwrite", 64'(pwrite), 64'(s.write));
               chk("apb_pstb", 64'(pstb), 64'(s.pstb));
               if (s.write) chk("apb_pdata", 64'(pdata), s.pdata);
               prdata = s.prdata; perr = s.perr; pready = 1'b0;
               n = 0;
               @(negedge clk);
               while (penable && n < 64) begin
                  n++;
                  chk("apb_psel_held", 64'(psel), 64'd1);
                  pready = !s.tmo && (n > s.waits);
                  @(negedge clk);
               end
               pready = 1'b0; perr = 1'b0;
               if (!s.abort) begin
                  chk("apb_penable_cycles", 64'(n), s.tmo ? 64'(TMO) : 64'(s.waits + 1));
                  chk("apb_psel_drop", 64'(psel), 64'd0);
               end
            end
         end
      end
   end

   always @(negedge clk) begin : mon32
      rsp_t e;
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_rdata", 64'(rsp_rdata), e.rdata);
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin : mon64
      rsp_t e;
      if (rst_n && q_rsp_valid) begin
         if (exp64_q.size() == 0) begin
            chk("q_rsp_unexpected", 64'(q_rsp_valid), 64'd0);
         end else begin
            e = exp64_q.pop_front();
            chk("q_rsp_err", 64'(q_rsp_err), 64'(e.err));
            chk("q_rsp_rdata", q_rsp_rdata, e.rdata);
            chk("q_rsp_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin : stim
      int b, sz;
      bit wr, sgn, be, tmo;
      int waits;
      logic [31:0] addr;
      logic [63:0] a64;

      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      q_req_valid = 1'b0; q_req_write = 1'b0; q_req_size = '0; q_req_signed = 1'b0;
      q_req_addr = '0; q_req_wdata = '0; q_prdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_psel_pen_pwr", {61'd0, psel, penable, pwrite}, 64'd0);
      chk("rst_paddr", 64'(paddr), 64'd0);
      chk("rst_pdata", 64'(pdata), 64'd0);
      chk("rst_pstb", 64'(pstb), 64'hF);
      chk("rst_q_pstb", 64'(q_pstb), 64'hFF);
      rst_n = 1'b1;

      // Directed scenarios
      issue(1, 2, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0);
      issue(0, 0, 1, 32'h203, 32'h0, 32'h80123456, 0, 0, 0, 0);
      issue(0, 0, 0, 32'h203, 32'h0, 32'h80123456, 0, 0, 0, 0);
      issue(1, 1, 0, 32'h302, 32'h00001234, 32'h0, 0, 0, 0, 0);
      issue(0, 1, 0, 32'h301, 32'h0, 32'h0, 0, 0, 0, 0);
      issue(0, 2, 0, 32'h400, 32'h0, 32'hCAFEF00D, 3, 1, 0, 0);
      issue(0, 2, 0, 32'h500, 32'h0, 32'h12345678, 0, 0, 1, 0);
      issue(0, 2, 1, 32'h504, 32'h0, 32'h89ABCDEF, 1, 0, 0, 0);
      issue(0, 3, 0, 32'h8, 32'h0, 32'h0, 0, 0, 0, 0);
      issue(0, 1, 1, 32'h602, 32'h0, 32'h8001_7FFF, 2, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         sz = $urandom_range(0, 3);
         wr = 1'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % (32'd1 << sz));
         waits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
         be = ($urandom_range(0, 7) == 0);
         tmo = ($urandom_range(0, 15) == 0);
         issue(wr, sz, sgn, addr, $urandom, $urandom, waits, be, tmo, 0);
      end

      // Reset during ACCESS aborts the transfer without a response
      issue(0, 2, 0, 32'h700, 32'h0, 32'h0, 0, 0, 1, 1);
      @(negedge clk);
      chk("abort_in_access", 64'(penable), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("abort_psel_pen", {62'd0, psel, penable}, 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_req_ready", 64'(req_ready), 64'd1);
      repeat (12) @(negedge clk);
      chk("abort_no_rsp", 64'(exp_q.size()), 64'd0);
      issue(0, 2, 0, 32'h800, 32'h0, 32'h55AA_33CC, 0, 0, 0, 0);

      // 64-bit bus
      issue64(0, 3, 0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF);
      issue64(0, 0, 1, 32'h15, 64'h0, 64'h0000_A500_0000_0000);
      issue64(1, 2, 0, 32'h4, 64'h1122_3344, 64'h0);
      issue64(0, 1, 0, 32'h16, 64'h0, 64'hF00D_0000_0000_0000);
      issue64(0, 2, 1, 32'h4, 64'h0, 64'h8765_4321_0000_0000);
      issue64(0, 3, 0, 32'hC, 64'h0, 64'h0);
      for (int i = 0; i < 30; i++) begin
         sz = $urandom_range(0, 3);
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % (32'd1 << sz));
         a64 = {$urandom, $urandom};
         issue64(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, a64,
                 {$urandom, $urandom});
      end

      b = 0;
      while ((exp_q.size() != 0 || exp64_q.size() != 0) && b < 200) begin
         @(negedge clk);
         b++;
      end
      chk("drain_rsp32", 64'(exp_q.size()), 64'd0);
      chk("drain_rsp64", 64'(exp64_q.size()), 64'd0);
      chk("drain_apb", 64'(slv_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
